// File: rtl/io_port.sv
// rtl/io_port.sv - board-side output registers, debounced switch input and 4-digit seven-segment scan
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-low reset
//   LdOUTPUT   output load request (level); a write fires on its rising edge only
//   EndOUT     destination output register index
//   ResultULA  data written into the selected output register
//   SW         raw asynchronous board switches
//   DadoIN     synchronised, debounced switch value
//   OUT0..OUT3 output registers
//   OutStrobe  one-cycle pulse following an output register write
//   an_n       active-low one-hot digit enables
//   seg_n      active-low segments, bit order gfedcba
module io_port #(
    parameter int DEB_CYCLES = 4,
    parameter int SCAN_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       LdOUTPUT,
    input  logic [1:0] EndOUT,
    input  logic [7:0] ResultULA,
    input  logic [7:0] SW,
    output logic [7:0] DadoIN,
    output logic [7:0] OUT0,
    output logic [7:0] OUT1,
    output logic [7:0] OUT2,
    output logic [7:0] OUT3,
    output logic       OutStrobe,
    output logic [3:0] an_n,
    output logic [6:0] seg_n
);

    localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DCW-1:0] DEB_MAX  = DCW'(DEB_CYCLES - 1);
    localparam logic [SCW-1:0] SCAN_MAX = SCW'(SCAN_DIV - 1);

    logic [7:0]     out_q [4];
    logic           ld_q;
    logic [7:0]     s1, s2, cand;
    logic [DCW-1:0] deb_cnt;
    logic [SCW-1:0] scan_cnt;
    logic [1:0]     digit;
    logic [3:0]     nibble;
    logic           wr_fire;

    // Edge detect so a held load level produces exactly one write.
    assign wr_fire = LdOUTPUT & ~ld_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q[0]  <= 8'h00;
            out_q[1]  <= 8'h00;
            out_q[2]  <= 8'h00;
            out_q[3]  <= 8'h00;
            ld_q      <= 1'b0;
            OutStrobe <= 1'b0;
            s1        <= 8'h00;
            s2        <= 8'h00;
            cand      <= 8'h00;
            deb_cnt   <= '0;
            DadoIN    <= 8'h00;
            scan_cnt  <= '0;
            digit     <= 2'd0;
        end else begin
            ld_q      <= LdOUTPUT;
            OutStrobe <= wr_fire;
            if (wr_fire) begin
                out_q[EndOUT] <= ResultULA;
            end

            s1   <= SW;
            s2   <= s1;
            cand <= s2;
            // Count consecutive cycles the synchronised value has held a new value;
            // any movement, or settling back to the committed value, restarts the count.
            if ((s2 != cand) || (s2 == DadoIN)) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_MAX) begin
                DadoIN  <= s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DCW'(1);
            end

            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                digit    <= digit + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + SCW'(1);
            end
        end
    end

    assign OUT0 = out_q[0];
    assign OUT1 = out_q[1];
    assign OUT2 = out_q[2];
    assign OUT3 = out_q[3];

    // Nibble and enable selection read the live registers, so a write shows up
    // on the display the cycle after it lands.
    always_comb begin
        nibble = out_q[0][3:0];
        an_n   = 4'b1110;
        case (digit)
            2'd0: begin nibble = out_q[0][3:0]; an_n = 4'b1110; end
            2'd1: begin nibble = out_q[0][7:4]; an_n = 4'b1101; end
            2'd2: begin nibble = out_q[1][3:0]; an_n = 4'b1011; end
            default: begin nibble = out_q[1][7:4]; an_n = 4'b0111; end
        endcase
    end

    always_comb begin
        seg_n = 7'b1000000;
        case (nibble)
            4'h0: seg_n = 7'b1000000;
            4'h1: seg_n = 7'b1111001;
            4'h2: seg_n = 7'b0100100;
            4'h3: seg_n = 7'b0110000;
            4'h4: seg_n = 7'b0011001;
            4'h5: seg_n = 7'b0010010;
            4'h6: seg_n = 7'b0000010;
            4'h7: seg_n = 7'b1111000;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0010000;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b0000011;
            4'hC: seg_n = 7'b1000110;
            4'hD: seg_n = 7'b0100001;
            4'hE: seg_n = 7'b0000110;
            default: seg_n = 7'b0001110;
        endcase
    end

endmodule

// File: tb/tb_io_port.sv
// tb/tb_io_port.sv - randomized and directed self-checking bench for io_port
module tb_io_port;

    localparam int DEB  = 4;
    localparam int SDIV = 4;

    logic       clk;
    logic       rst;
    logic       LdOUTPUT;
    logic [1:0] EndOUT;
    logic [7:0] ResultULA;
    logic [7:0] SW;
    logic [7:0] DadoIN;
    logic [7:0] OUT0, OUT1, OUT2, OUT3;
    logic       OutStrobe;
    logic [3:0] an_n;
    logic [6:0] seg_n;

    io_port #(.DEB_CYCLES(DEB), .SCAN_DIV(SDIV)) dut (
        .clk(clk), .rst(rst), .LdOUTPUT(LdOUTPUT), .EndOUT(EndOUT),
        .ResultULA(ResultULA), .SW(SW), .DadoIN(DadoIN),
        .OUT0(OUT0), .OUT1(OUT1), .OUT2(OUT2), .OUT3(OUT3),
        .OutStrobe(OutStrobe), .an_n(an_n), .seg_n(seg_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] m_out [4];
    logic       m_prev_ld;
    logic       m_strobe;
    logic [7:0] m_dado;
    logic [7:0] m_hist [$];   // SW value seen at each clock edge, oldest first
    int         m_cyc;        // edges since reset release
    logic [6:0] seg_tab [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
        m_prev_ld = 1'b0;
        m_strobe  = 1'b0;
        m_dado    = 8'h00;
        m_cyc     = 0;
        m_hist.delete();
        for (int i = 0; i < DEB + 3; i++) m_hist.push_back(8'h00);
    endtask

    task automatic check_all(input string ph);
        int         dig;
        logic [7:0] v;
        logic [3:0] nib;
        dig = (m_cyc / SDIV) % 4;
        v   = (dig < 2) ? m_out[0] : m_out[1];
        nib = (dig % 2 == 0) ? v[3:0] : v[7:4];
        chk({ph, ".OUT0"}, {24'd0, OUT0}, {24'd0, m_out[0]});
        chk({ph, ".OUT1"}, {24'd0, OUT1}, {24'd0, m_out[1]});
        chk({ph, ".OUT2"}, {24'd0, OUT2}, {24'd0, m_out[2]});
        chk({ph, ".OUT3"}, {24'd0, OUT3}, {24'd0, m_out[3]});
        chk({ph, ".OutStrobe"}, {31'd0, OutStrobe}, {31'd0, m_strobe});
        chk({ph, ".DadoIN"}, {24'd0, DadoIN}, {24'd0, m_dado});
        chk({ph, ".an_n"}, {28'd0, an_n}, {28'd0, ~(4'b0001 << dig)});
        chk({ph, ".seg_n"}, {25'd0, seg_n}, {25'd0, seg_tab[nib]});
    endtask

    // One clock: inputs are captured as the DUT sees them, model advances on
    // the edge, and outputs are checked on the following falling edge.
    task automatic tick(input string ph);
        logic       ld_in;
        logic [1:0] a_in;
        logic [7:0] d_in, sw_in;
        logic       all_same;
        int         n;
        ld_in = LdOUTPUT; a_in = EndOUT; d_in = ResultULA; sw_in = SW;
        @(posedge clk);
        m_strobe = ld_in && !m_prev_ld;
        if (m_strobe) m_out[a_in] = d_in;
        m_prev_ld = ld_in;
        m_hist.push_back(sw_in);
        void'(m_hist.pop_front());
        // Synchroniser delays SW by two edges; commit once DEB+1 consecutive
        // synchronised samples agree and differ from the committed value.
        n = m_hist.size();
        all_same = 1'b1;
        for (int j = 0; j <= DEB; j++)
            if (m_hist[n - 3 - j] !== m_hist[n - 3]) all_same = 1'b0;
        if (all_same && (m_hist[n - 3] !== m_dado)) m_dado = m_hist[n - 3];
        m_cyc++;
        @(negedge clk);
        check_all(ph);
    endtask

    initial begin
        int strobes;
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        rst = 1'b0; LdOUTPUT = 1'b0; EndOUT = 2'd0; ResultULA = 8'h00; SW = 8'h00;
        model_reset();
        #2;
        check_all("por");
        @(negedge clk);
        rst = 1'b1;

        // Debounce accept: commit exactly at edge 7
        SW = 8'hA5;
        for (int i = 0; i < 6; i++) tick("deb_acc");
        chk("deb_edge6", {24'd0, DadoIN}, 32'h00);
        tick("deb_acc");
        chk("deb_edge7", {24'd0, DadoIN}, 32'hA5);

        // Debounce reject: short pulse, then bouncing
        SW = 8'h00;
        for (int i = 0; i < 10; i++) tick("deb_back");
        SW = 8'hFF;
        for (int i = 0; i < 3; i++) tick("deb_rej");
        SW = 8'h00;
        for (int i = 0; i < 10; i++) tick("deb_rej");
        chk("deb_rej_hold", {24'd0, DadoIN}, 32'h00);
        for (int i = 0; i < 8; i++) begin
            SW = (i % 2 == 0) ? 8'hA5 : 8'h5A;
            tick("bounce"); tick("bounce");
        end
        chk("bounce_hold", {24'd0, DadoIN}, 32'h00);
        for (int i = 0; i < 8; i++) tick("bounce_settle");

        // Held write: one write, one strobe
        EndOUT = 2'd2; ResultULA = 8'h5A; LdOUTPUT = 1'b1;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            tick("held");
            strobes += int'(OutStrobe);
            EndOUT = 2'd1; ResultULA = 8'hFF;
        end
        LdOUTPUT = 1'b0;
        tick("held");
        strobes += int'(OutStrobe);
        chk("held_strobes", strobes, 1);
        chk("held_out2", {24'd0, OUT2}, 32'h5A);

        // Four writes with one-cycle gaps
        strobes = 0;
        for (int a = 0; a < 4; a++) begin
            EndOUT = 2'(a); ResultULA = 8'(8'h11 * (a + 1)); LdOUTPUT = 1'b1;
            tick("four");
            strobes += int'(OutStrobe);
            LdOUTPUT = 1'b0;
            tick("four");
            strobes += int'(OutStrobe);
        end
        chk("four_strobes", strobes, 4);
        chk("four_out3", {24'd0, OUT3}, 32'h44);

        // Scan sequence over OUT0=3C, OUT1=E7
        EndOUT = 2'd0; ResultULA = 8'h3C; LdOUTPUT = 1'b1; tick("scan_wr");
        LdOUTPUT = 1'b0; tick("scan_wr");
        EndOUT = 2'd1; ResultULA = 8'hE7; LdOUTPUT = 1'b1; tick("scan_wr");
        LdOUTPUT = 1'b0;
        for (int i = 0; i < 2 * 4 * SDIV; i++) tick("scan");

        // Asynchronous reset mid-write and mid-debounce
        SW = 8'h3D; LdOUTPUT = 1'b1; EndOUT = 2'd3; ResultULA = 8'h99;
        tick("pre_rst"); tick("pre_rst");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        LdOUTPUT = 1'b0; SW = 8'h00;
        @(negedge clk);
        check_all("rst_hold");
        rst = 1'b1;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            LdOUTPUT  = ($urandom_range(0, 2) == 0);
            EndOUT    = 2'($urandom_range(0, 3));
            ResultULA = 8'($urandom);
            if ($urandom_range(0, 9) == 0) SW = 8'($urandom);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
